// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared definitions for the pipeline memory stage.
//   EX_MEM / MEM_WB field bit offsets, MemToReg encodings, FSM state type.
//   No ports (package).
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;

  // EX_MEM bundle layout (139 bits)
  localparam int unsigned EXM_W          = 139;
  localparam int unsigned EXM_WDATA_LSB  = 0;
  localparam int unsigned EXM_ALU_LSB    = 32;
  localparam int unsigned EXM_RD_LSB     = 64;
  localparam int unsigned EXM_MEMREAD    = 69;
  localparam int unsigned EXM_MEMWRITE   = 70;
  localparam int unsigned EXM_REGWRITE   = 71;
  localparam int unsigned EXM_MTR_LSB    = 72;
  localparam int unsigned EXM_PC4_LSB    = 74;
  localparam int unsigned EXM_LUDATA_LSB = 106;
  localparam int unsigned EXM_LUOP       = 138;

  // MEM_WB bundle layout (38 bits)
  localparam int unsigned MWB_W        = 38;
  localparam int unsigned MWB_DATA_LSB = 0;
  localparam int unsigned MWB_RD_LSB   = 32;
  localparam int unsigned MWB_REGWRITE = 37;

  // MemToReg encodings; 2'b11 is legal and selects the ALU result
  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if -- data-memory req/ack bus.
//   dmem_req   : access request (held until ack or abort)
//   dmem_we    : 1 = write
//   dmem_addr  : word address
//   dmem_wdata : store data
//   dmem_rdata : read data, valid with ack
//   dmem_ack   : single-cycle completion pulse
//   master = memory stage side, slave = memory side.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage_wb_mux.sv
// mem_wb_mux -- combinational writeback value select.
//   i_lu_op      : select LUData over everything else
//   i_mem_to_reg : MemToReg source select
//   i_alu        : ALU result
//   i_mem_data   : loaded data
//   i_pc_plus4   : PC+4
//   i_lu_data    : LUData
//   o_data       : selected value
//   MEM_SEL = 0 builds the forwarding variant, where MemToReg 01 yields the
//   ALU result because loaded data is not yet available for forwarding.
module mem_wb_mux
  import mem_stage_pkg::*;
#(
  parameter bit MEM_SEL = 1'b1
) (
  input  logic              i_lu_op,
  input  logic [1:0]        i_mem_to_reg,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [DATA_W-1:0] i_pc_plus4,
  input  logic [DATA_W-1:0] i_lu_data,
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_data = i_alu;
    if (i_lu_op) begin
      o_data = i_lu_data;
    end else begin
      case (i_mem_to_reg)
        MTR_MEM: o_data = MEM_SEL ? i_mem_data : i_alu;
        MTR_PC:  o_data = i_pc_plus4;
        default: o_data = i_alu;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- pipeline memory stage.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   EX_MEM       : 139-bit bundle from execute
//   dmem         : data-memory bus (mem_stage_if.master)
//   stall        : freeze PC/IF_ID/ID_EX/EX_MEM while an access is pending
//   fwd_rd/fwd_data/fwd_regwrite : forwarding back to execute
//   MEM_WB       : registered {RegWrite, WriteReg, WbData}
//   bus_err      : sticky dmem timeout flag
//   align_err    : sticky misalignment flag
// Optional: define MEM_STAGE_ALIGN_CHECK_EN to reject accesses with
// addr[1:0] != 0 (no request issued, load returns 0, align_err set).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [EXM_W-1:0]  EX_MEM,
  mem_stage_if.master       dmem,
  output logic              stall,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_regwrite,
  output logic [MWB_W-1:0]  MEM_WB,
  output logic              bus_err,
  output logic              align_err
);

  logic [DATA_W-1:0] w_wdata, w_addr, w_pc4, w_ludata;
  logic [RD_W-1:0]   w_rd;
  logic [1:0]        w_mtr;
  logic              w_memread, w_memwrite, w_regwrite, w_luop;
  logic              w_acc, w_is_load, w_misaligned;
  logic [DATA_W-1:0] w_wb_data, w_fwd_data;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req;
  logic [DATA_W-1:0] r_rdata_q;
  logic              r_bus_err;
  logic [MWB_W-1:0]  r_mem_wb;

  assign w_wdata    = EX_MEM[EXM_WDATA_LSB +: DATA_W];
  assign w_addr     = EX_MEM[EXM_ALU_LSB +: DATA_W];
  assign w_rd       = EX_MEM[EXM_RD_LSB +: RD_W];
  assign w_memread  = EX_MEM[EXM_MEMREAD];
  assign w_memwrite = EX_MEM[EXM_MEMWRITE];
  assign w_regwrite = EX_MEM[EXM_REGWRITE];
  assign w_mtr      = EX_MEM[EXM_MTR_LSB +: 2];
  assign w_pc4      = EX_MEM[EXM_PC4_LSB +: DATA_W];
  assign w_ludata   = EX_MEM[EXM_LUDATA_LSB +: DATA_W];
  assign w_luop     = EX_MEM[EXM_LUOP];

  assign w_acc     = w_memread | w_memwrite;
  // MemRead together with MemWrite is treated as a write
  assign w_is_load = w_memread & ~w_memwrite;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic r_align_err;

  assign w_misaligned = (w_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_align_err <= 1'b0;
    end else if (r_state == ST_IDLE && w_acc && w_misaligned) begin
      r_align_err <= 1'b1;
    end
  end

  assign align_err = r_align_err;
`else
  assign w_misaligned = 1'b0;
  assign align_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_rdata_q <= '0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_acc) begin
            if (w_misaligned) begin
              r_rdata_q <= '0;
              r_state   <= ST_DONE;
            end else begin
              r_req   <= 1'b1;
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // ack wins over a timeout landing in the same cycle
          if (dmem.dmem_ack) begin
            if (w_is_load) begin
              r_rdata_q <= dmem.dmem_rdata;
            end
            r_req   <= 1'b0;
            r_state <= ST_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_req     <= 1'b0;
            r_rdata_q <= '0;
            r_bus_err <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall = w_acc & (r_state != ST_DONE);

  mem_wb_mux #(.MEM_SEL(1'b1)) u_wb_mux (
    .i_lu_op      (w_luop),
    .i_mem_to_reg (w_mtr),
    .i_alu        (w_addr),
    .i_mem_data   (r_rdata_q),
    .i_pc_plus4   (w_pc4),
    .i_lu_data    (w_ludata),
    .o_data       (w_wb_data)
  );

  mem_wb_mux #(.MEM_SEL(1'b0)) u_fwd_mux (
    .i_lu_op      (w_luop),
    .i_mem_to_reg (w_mtr),
    .i_alu        (w_addr),
    .i_mem_data   (r_rdata_q),
    .i_pc_plus4   (w_pc4),
    .i_lu_data    (w_ludata),
    .o_data       (w_fwd_data)
  );

  always_ff @(posedge clk) begin
    if (reset || stall) begin
      r_mem_wb <= '0;
    end else begin
      r_mem_wb[MWB_DATA_LSB +: DATA_W] <= w_wb_data;
      r_mem_wb[MWB_RD_LSB +: RD_W]     <= w_rd;
      r_mem_wb[MWB_REGWRITE]           <= w_regwrite & (w_rd != '0);
    end
  end

  assign MEM_WB       = r_mem_wb;
  assign bus_err      = r_bus_err;
  assign fwd_rd       = w_rd;
  assign fwd_data     = w_fwd_data;
  assign fwd_regwrite = w_regwrite & (w_mtr != MTR_MEM) & (w_rd != '0);

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = w_memwrite;
  assign dmem.dmem_addr  = w_addr;
  assign dmem.dmem_wdata = w_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage (TIMEOUT_CYCLES = 4).
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [138:0] EX_MEM;
  logic         stall;
  logic [4:0]   fwd_rd;
  logic [31:0]  fwd_data;
  logic         fwd_regwrite;
  logic [37:0]  MEM_WB;
  logic         bus_err;
  logic         align_err;

  mem_stage_if dmem ();

  mem_stage #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .EX_MEM       (EX_MEM),
    .dmem         (dmem),
    .stall        (stall),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .fwd_regwrite (fwd_regwrite),
    .MEM_WB       (MEM_WB),
    .bus_err      (bus_err),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [138:0] mk(input logic luop, input logic [31:0] lud,
                                      input logic [31:0] pc4, input logic [1:0] mtr,
                                      input logic rw, input logic mw, input logic mr,
                                      input logic [4:0] rd, input logic [31:0] alu,
                                      input logic [31:0] wd);
    return {luop, lud, pc4, mtr, rw, mw, mr, rd, alu, wd};
  endfunction

  typedef struct {
    logic        luop;
    logic [1:0]  mtr;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] lud;
    logic [37:0] exp_wb;
    logic [31:0] exp_fwd;
    logic        exp_frw;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // non-memory ops; run right after reset so loaded-data register is 0
    vecs[0] = '{1'b0, 2'b00, 1'b1, 5'd8,  32'h1234, 32'h100,  32'hAAAA0000, {1'b1, 5'd8,  32'h1234},     32'h1234,     1'b1};
    vecs[1] = '{1'b0, 2'b10, 1'b1, 5'd31, 32'h5,    32'h2004, 32'h0,        {1'b1, 5'd31, 32'h2004},     32'h2004,     1'b1};
    vecs[2] = '{1'b1, 2'b00, 1'b1, 5'd3,  32'h7,    32'h0,    32'h12340000, {1'b1, 5'd3,  32'h12340000}, 32'h12340000, 1'b1};
    vecs[3] = '{1'b0, 2'b11, 1'b1, 5'd4,  32'hCAFE, 32'h44,   32'h0,        {1'b1, 5'd4,  32'hCAFE},     32'hCAFE,     1'b1};
    vecs[4] = '{1'b0, 2'b01, 1'b1, 5'd5,  32'h77,   32'h0,    32'h0,        {1'b1, 5'd5,  32'h0},        32'h77,       1'b0};
    vecs[5] = '{1'b0, 2'b00, 1'b1, 5'd0,  32'h99,   32'h0,    32'h0,        {1'b0, 5'd0,  32'h99},       32'h99,       1'b0};
    vecs[6] = '{1'b0, 2'b00, 1'b0, 5'd10, 32'h42,   32'h0,    32'h0,        {1'b0, 5'd10, 32'h42},       32'h42,       1'b0};
    vecs[7] = '{1'b1, 2'b10, 1'b1, 5'd2,  32'h1,    32'h8,    32'hFFFF0000, {1'b1, 5'd2,  32'hFFFF0000}, 32'hFFFF0000, 1'b1};

    reset           = 1'b1;
    EX_MEM          = '0;
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_req",       {63'd0, dmem.dmem_req}, 64'd0);
    chk("rst_mem_wb",    {26'd0, MEM_WB},        64'd0);
    chk("rst_bus_err",   {63'd0, bus_err},       64'd0);
    chk("rst_align_err", {63'd0, align_err},     64'd0);
    chk("rst_stall",     {63'd0, stall},         64'd0);

    // table: non-memory ops pass in one cycle
    for (int i = 0; i < 8; i++) begin
      EX_MEM = mk(vecs[i].luop, vecs[i].lud, vecs[i].pc4, vecs[i].mtr, vecs[i].rw,
                  1'b0, 1'b0, vecs[i].rd, vecs[i].alu, 32'h0);
      #1;
      chk($sformatf("v%0d_stall", i),    {63'd0, stall},        64'd0);
      chk($sformatf("v%0d_fwd_data", i), {32'd0, fwd_data},     {32'd0, vecs[i].exp_fwd});
      chk($sformatf("v%0d_fwd_rw", i),   {63'd0, fwd_regwrite}, {63'd0, vecs[i].exp_frw});
      chk($sformatf("v%0d_fwd_rd", i),   {59'd0, fwd_rd},       {59'd0, vecs[i].rd});
      step();
      chk($sformatf("v%0d_mem_wb", i),   {26'd0, MEM_WB},       {26'd0, vecs[i].exp_wb});
    end

    // load 0x40 -> r9, ack on second BUSY cycle
    EX_MEM = mk(1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd9, 32'h40, 32'h0);
    #1;
    chk("ld_c0_stall", {63'd0, stall},          64'd1);
    chk("ld_c0_req",   {63'd0, dmem.dmem_req},  64'd0);
    chk("ld_c0_we",    {63'd0, dmem.dmem_we},   64'd0);
    chk("ld_addr",     {32'd0, dmem.dmem_addr}, 64'h40);
    chk("ld_fwd_rw",   {63'd0, fwd_regwrite},   64'd0);
    step();
    chk("ld_c1_req",   {63'd0, dmem.dmem_req},  64'd1);
    chk("ld_c1_stall", {63'd0, stall},          64'd1);
    chk("ld_c1_wb",    {26'd0, MEM_WB},         64'd0);
    step();
    chk("ld_c2_req",   {63'd0, dmem.dmem_req},  64'd1);
    chk("ld_c2_stall", {63'd0, stall},          64'd1);
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hDEADBEEF;
    step();
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = 32'h0;
    chk("ld_c3_req",   {63'd0, dmem.dmem_req},  64'd0);
    chk("ld_c3_stall", {63'd0, stall},          64'd0);
    chk("ld_c3_wb",    {26'd0, MEM_WB},         64'd0);
    step();
    chk("ld_wb",       {26'd0, MEM_WB},         {26'd0, 1'b1, 5'd9, 32'hDEADBEEF});
    EX_MEM = '0;

    // store 0x55AA to 0x80, ack in first BUSY cycle
    step();
    EX_MEM = mk(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd6, 32'h80, 32'h55AA);
    #1;
    chk("st_we",       {63'd0, dmem.dmem_we},    64'd1);
    chk("st_wdata",    {32'd0, dmem.dmem_wdata}, 64'h55AA);
    chk("st_c0_stall", {63'd0, stall},           64'd1);
    step();
    chk("st_c1_req",   {63'd0, dmem.dmem_req},   64'd1);
    dmem.dmem_ack = 1'b1;
    step();
    dmem.dmem_ack = 1'b0;
    chk("st_c2_req",   {63'd0, dmem.dmem_req},   64'd0);
    chk("st_c2_stall", {63'd0, stall},           64'd0);
    step();
    chk("st_c3_req",   {63'd0, dmem.dmem_req},   64'd0);
    chk("st_wb",       {26'd0, MEM_WB},          {26'd0, 1'b0, 5'd6, 32'h80});
    EX_MEM = '0;

    // load with no ack -> timeout after 4 BUSY cycles
    step();
    EX_MEM = mk(1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd12, 32'h100, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("to_busy%0d_req", c), {63'd0, dmem.dmem_req}, 64'd1);
    end
    step();
    chk("to_req_drop", {63'd0, dmem.dmem_req}, 64'd0);
    chk("to_bus_err",  {63'd0, bus_err},       64'd1);
    chk("to_stall",    {63'd0, stall},         64'd0);
    step();
    chk("to_wb",       {26'd0, MEM_WB},        {26'd0, 1'b1, 5'd12, 32'h0});
    EX_MEM = '0;
    step();
    chk("to_sticky",   {63'd0, bus_err},       64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("to_rst_clr",  {63'd0, bus_err},       64'd0);

    // reset in the middle of BUSY, then a stray ack
    EX_MEM = mk(1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd9, 32'h40, 32'h0);
    step();
    step();
    chk("mr_busy_req", {63'd0, dmem.dmem_req}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_req",      {63'd0, dmem.dmem_req}, 64'd0);
    chk("mr_wb",       {26'd0, MEM_WB},        64'd0);
    EX_MEM          = '0;
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hBAD0BAD0;
    step();
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = 32'h0;
    chk("mr_ack_noreq", {63'd0, dmem.dmem_req}, 64'd0);
    // MemToReg=01 without access exposes the load register: must still be 0
    EX_MEM = mk(1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 5'd7, 32'h3, 32'h0);
    step();
    chk("mr_ack_ignored", {26'd0, MEM_WB}, {26'd0, 1'b1, 5'd7, 32'h0});
    EX_MEM = '0;
    step();

    // misaligned load at 0x42
    EX_MEM = mk(1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd11, 32'h42, 32'h0);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    #1;
    chk("al_c0_stall", {63'd0, stall},         64'd1);
    step();
    chk("al_req",      {63'd0, dmem.dmem_req}, 64'd0);
    chk("al_err",      {63'd0, align_err},     64'd1);
    chk("al_stall",    {63'd0, stall},         64'd0);
    step();
    chk("al_wb",       {26'd0, MEM_WB},        {26'd0, 1'b1, 5'd11, 32'h0});
    EX_MEM = '0;
    step();
    chk("al_sticky",   {63'd0, align_err},     64'd1);
`else
    step();
    chk("ua_req",      {63'd0, dmem.dmem_req},  64'd1);
    chk("ua_addr",     {32'd0, dmem.dmem_addr}, 64'h42);
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'h0BADF00D;
    step();
    dmem.dmem_ack   = 1'b0;
    chk("ua_align_err", {63'd0, align_err},    64'd0);
    step();
    chk("ua_wb",       {26'd0, MEM_WB},        {26'd0, 1'b1, 5'd11, 32'h0BADF00D});
    EX_MEM = '0;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
